osc_trig_capture: RTL and testbench

OSC_TRIG_CAPTURE -- requirements
Module: osc_trig_capture

---
 rtl/osc_trig_capture.sv | 228 ++++++++++++++++++++++
 tb/tb_osc_trig_capture.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/osc_trig_capture.sv
// osc_trig_capture: edge-triggered capture buffer for a decimated 8-bit ADC
// stream. PRE_TRIG samples before the trigger and DEPTH-PRE_TRIG from it on.
// Optional feature macro: OSC_AUTO_TRIG_EN forces a trigger after
// AUTO_TIMEOUT decimated samples spent waiting (auto_trig flags it).
// Ports:
//   ad_clk, rst            - clock, synchronous active-high reset
//   ad_data_in             - unsigned ADC sample, valid every cycle
//   arm                    - one-cycle pulse, starts or restarts a capture
//   trig_level, trig_edge  - threshold, 0 = rising / 1 = falling
//   fre_choose             - decimation 2^fre_choose
//   rd_addr, rd_data       - frame readback, 0 = oldest, 1-cycle latency
//   frame_ready, busy      - frame held / capture in progress
//   auto_trig              - held frame was force-triggered

module osc_trig_capture #(
    parameter int  DEPTH        = 1024,
    parameter int  PRE_TRIG     = 512,
    parameter int  AUTO_TIMEOUT = 1048576,
    localparam int AW           = $clog2(DEPTH)
) (
    input  logic          ad_clk,
    input  logic          rst,
    input  logic [7:0]    ad_data_in,
    input  logic          arm,
    input  logic [7:0]    trig_level,
    input  logic          trig_edge,
    input  logic [1:0]    fre_choose,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data,
    output logic          frame_ready,
    output logic          busy,
    output logic          auto_trig
);

    localparam int POST_LEN = DEPTH - PRE_TRIG;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE,
        S_WAIT,
        S_POST,
        S_DONE
    } state_t;

    state_t state_q;
    state_t state_nx;

    logic [7:0]    lvl_q;
    logic          fall_q;
    logic [1:0]    dec_q;
    logic [2:0]    div_cnt;
    logic [2:0]    div_max;
    logic [AW-1:0] pre_cnt;
    logic [AW-1:0] post_cnt;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] trig_addr;
    logic [AW-1:0] rd_phys;
    logic [7:0]    prev_smp;
    logic          prev_valid;
    logic          strobe;
    logic          we;
    logic          done_set;
    logic          pre_last;
    logic          post_last;
    logic          trig_hit;
    logic          force_trig;
    logic          fire;

    logic [7:0] mem [DEPTH];

    // ---------------- state register ----------------
    always_ff @(posedge ad_clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_nx;
        end
    end

    // ---------------- next state ----------------
    always_comb begin
        state_nx = state_q;
        unique case (state_q)
            S_IDLE: state_nx = S_IDLE;
            S_PRE: begin
                if (strobe && pre_last) state_nx = S_WAIT;
            end
            S_WAIT: begin
                if (strobe && fire) begin
                    state_nx = (POST_LEN == 1) ? S_DONE : S_POST;
                end
            end
            S_POST: begin
                if (strobe && post_last) state_nx = S_DONE;
            end
            S_DONE: state_nx = S_DONE;
            default: state_nx = S_IDLE;
        endcase
        // arm restarts from any state and beats a coinciding last sample
        if (arm) state_nx = S_PRE;
    end

    // ---------------- outputs / strobes ----------------
    always_comb begin
        busy     = (state_q == S_PRE) || (state_q == S_WAIT)
                || (state_q == S_POST);
        strobe   = busy && (div_cnt == 3'd0);
        we       = strobe && !arm && !rst;
        done_set = (state_nx == S_DONE) && (state_q != S_DONE);
    end

    always_comb begin
        unique case (dec_q)
            2'd0:    div_max = 3'd0;
            2'd1:    div_max = 3'd1;
            2'd2:    div_max = 3'd3;
            default: div_max = 3'd7;
        endcase
    end

    assign pre_last  = (pre_cnt == AW'(PRE_TRIG - 1));
    assign post_last = (post_cnt == AW'(POST_LEN - 1));

    // trigger compares the previous strobed sample with the current one
    always_comb begin
        if (fall_q) begin
            trig_hit = prev_valid && (prev_smp > lvl_q)
                    && (ad_data_in <= lvl_q);
        end else begin
            trig_hit = prev_valid && (prev_smp < lvl_q)
                    && (ad_data_in >= lvl_q);
        end
    end

    assign fire = trig_hit || force_trig;

    // ---------------- datapath ----------------
    always_ff @(posedge ad_clk) begin
        if (rst) begin
            lvl_q       <= 8'd0;
            fall_q      <= 1'b0;
            dec_q       <= 2'd0;
            div_cnt     <= 3'd0;
            pre_cnt     <= '0;
            post_cnt    <= '0;
            wr_ptr      <= '0;
            trig_addr   <= '0;
            prev_smp    <= 8'd0;
            prev_valid  <= 1'b0;
            frame_ready <= 1'b0;
        end else if (arm) begin
            lvl_q       <= trig_level;
            fall_q      <= trig_edge;
            dec_q       <= fre_choose;
            div_cnt     <= 3'd0;
            pre_cnt     <= '0;
            post_cnt    <= '0;
            wr_ptr      <= '0;
            prev_valid  <= 1'b0;
            frame_ready <= 1'b0;
        end else begin
            if (busy) begin
                div_cnt <= (div_cnt == div_max) ? 3'd0 : div_cnt + 3'd1;
            end
            if (strobe) begin
                wr_ptr     <= wr_ptr + AW'(1);
                prev_smp   <= ad_data_in;
                prev_valid <= 1'b1;
                if (state_q == S_PRE) begin
                    pre_cnt <= pre_cnt + AW'(1);
                end
                if (state_q == S_WAIT && fire) begin
                    trig_addr <= wr_ptr;
                    post_cnt  <= AW'(1);
                end
                if (state_q == S_POST) begin
                    post_cnt <= post_cnt + AW'(1);
                end
            end
            if (done_set) frame_ready <= 1'b1;
        end
    end

`ifdef OSC_AUTO_TRIG_EN
    localparam int TW = $clog2(AUTO_TIMEOUT + 1);

    logic [TW-1:0] to_cnt;
    logic          auto_q;

    assign force_trig = (state_q == S_WAIT)
                     && (to_cnt == TW'(AUTO_TIMEOUT - 1));
    assign auto_trig  = auto_q;

    always_ff @(posedge ad_clk) begin
        if (rst) begin
            to_cnt <= '0;
            auto_q <= 1'b0;
        end else if (arm) begin
            to_cnt <= '0;
            auto_q <= 1'b0;
        end else if (strobe && state_q == S_WAIT) begin
            to_cnt <= to_cnt + TW'(1);
            // a genuine crossing on the timeout sample is not "forced"
            if (force_trig && !trig_hit) auto_q <= 1'b1;
        end
    end
`else
    assign force_trig = 1'b0;
    assign auto_trig  = 1'b0;
`endif

    // ---------------- sample buffer ----------------
    // oldest sample of the frame sits PRE_TRIG slots behind the trigger
    assign rd_phys = trig_addr - AW'(PRE_TRIG) + rd_addr;

    always_ff @(posedge ad_clk) begin
        if (we) mem[wr_ptr] <= ad_data_in;
    end

    always_ff @(posedge ad_clk) begin
        if (rst) begin
            rd_data <= 8'd0;
        end else begin
            rd_data <= mem[rd_phys];
        end
    end

endmodule

// File: tb/tb_osc_trig_capture.sv
// tb_osc_trig_capture: table vectors, random captures checked against a
// sample-list model, plus abort / coincident-arm / reset / timeout sequences.

module tb_osc_trig_capture;

    localparam int DEPTH = 1024;
    localparam int PRE   = 512;
    localparam int POST  = DEPTH - PRE;
    localparam int ATO   = 16;
    localparam int AW    = 10;

`ifdef OSC_AUTO_TRIG_EN
    localparam bit AUTO_EN = 1'b1;
`else
    localparam bit AUTO_EN = 1'b0;
`endif

    localparam int M_UP    = 0;
    localparam int M_DN    = 1;
    localparam int M_UPDN  = 2;
    localparam int M_CNT   = 3;
    localparam int M_CONST = 4;
    localparam int M_RAND  = 5;

    logic          ad_clk = 1'b0;
    logic          rst;
    logic [7:0]    ad_data_in;
    logic          arm;
    logic [7:0]    trig_level;
    logic          trig_edge;
    logic [1:0]    fre_choose;
    logic [AW-1:0] rd_addr;
    logic [7:0]    rd_data;
    logic          frame_ready;
    logic          busy;
    logic          auto_trig;

    int tests = 0;
    int fails = 0;
    int busy_bad;
    logic [7:0] cyc_q[$];

    typedef struct {
        int fre;
        bit fall;
        int lvl;
        int mode;
        int base;
        int rdy;
        int a0; int e0;
        int a1; int e1;
        int a2; int e2;
    } vec_t;

    vec_t vecs[4];

    osc_trig_capture #(
        .DEPTH(DEPTH),
        .PRE_TRIG(PRE),
        .AUTO_TIMEOUT(ATO)
    ) dut (
        .ad_clk(ad_clk),
        .rst(rst),
        .ad_data_in(ad_data_in),
        .arm(arm),
        .trig_level(trig_level),
        .trig_edge(trig_edge),
        .fre_choose(fre_choose),
        .rd_addr(rd_addr),
        .rd_data(rd_data),
        .frame_ready(frame_ready),
        .busy(busy),
        .auto_trig(auto_trig)
    );

    always #5 ad_clk = ~ad_clk;

    initial begin
        #5ms;
        $display("FAIL watchdog: run did not finish in time");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d",
                     name, $signed(act), $signed(exp));
        end
    endtask

    function automatic logic [7:0] gen(input int mode, input int base,
                                       input int n);
        case (mode)
            M_UP:   return 8'(base + n);
            M_DN:   return 8'(base - n);
            M_UPDN: begin
                if (n < 512) return 8'h30;
                if (n < 520) return 8'(8'h30 + 4 * (n - 512));
                return 8'(8'h4C - 2 * (n - 520));
            end
            M_CNT:   return 8'(n);
            M_CONST: return 8'(base);
            default: return 8'($urandom_range(0, 255));
        endcase
    endfunction

    // strobed sample k is the input of cycle k*2^dec after PRE entry;
    // trigger is the first crossing at or after sample PRE
    function automatic int model_trig(input int dec, input bit fall,
                                      input int lvl, output bit forced);
        int nstr;
        forced = 1'b0;
        if (cyc_q.size() == 0) return -1;
        nstr = ((cyc_q.size() - 1) >> dec) + 1;
        for (int k = PRE; k < nstr; k++) begin
            int p;
            int c;
            bit hit;
            p = int'(cyc_q[(k - 1) << dec]);
            c = int'(cyc_q[k << dec]);
            hit = fall ? (p > lvl && c <= lvl) : (p < lvl && c >= lvl);
            if (hit) return k;
            if (AUTO_EN && k == PRE + ATO - 1) begin
                forced = 1'b1;
                return k;
            end
        end
        return -1;
    endfunction

    task automatic arm_cfg(input int dec, input bit fall, input int lvl);
        arm        = 1'b1;
        fre_choose = 2'(dec);
        trig_edge  = fall;
        trig_level = 8'(lvl);
        ad_data_in = 8'h00;
        @(posedge ad_clk);
        #1;
        arm = 1'b0;
        cyc_q.delete();
    endtask

    task automatic drive(input int ncyc, input int mode, input int base,
                         output int ready_at);
        ready_at = -1;
        for (int i = 0; i < ncyc; i++) begin
            int n;
            n = cyc_q.size();
            ad_data_in = gen(mode, base, n);
            cyc_q.push_back(ad_data_in);
            @(posedge ad_clk);
            #1;
            if (frame_ready) begin
                ready_at = n;
                break;
            end
            if (!busy) busy_bad++;
        end
    endtask

    task automatic read_at(input int a, output logic [7:0] d);
        rd_addr = AW'(a);
        @(posedge ad_clk);
        #1;
        d = rd_data;
    endtask

    task automatic sweep(input int dec, input int t, output int bad);
        bad = 0;
        rd_addr = '0;
        @(posedge ad_clk);
        #1;
        for (int i = 1; i <= DEPTH; i++) begin
            int idx;
            logic [7:0] e;
            idx = (t - PRE + i - 1) << dec;
            e = (idx < cyc_q.size()) ? cyc_q[idx] : 8'hxx;
            if (rd_data !== e) bad++;
            if (i < DEPTH) rd_addr = AW'(i);
            @(posedge ad_clk);
            #1;
        end
    endtask

    task automatic full_capture(input int dec, input bit fall,
                                input int lvl, input int mode,
                                input int base, input int budget,
                                input string tag, output int rdy);
        int t;
        bit forced;
        int exp_rdy;
        int bad;
        arm_cfg(dec, fall, lvl);
        check({tag, " armed busy"}, busy, 1);
        check({tag, " armed ready"}, frame_ready, 0);
        busy_bad = 0;
        drive(budget, mode, base, rdy);
        t = model_trig(dec, fall, lvl, forced);
        exp_rdy = (t < 0) ? -1 : ((t + POST - 1) << dec);
        if (exp_rdy >= cyc_q.size()) exp_rdy = -1;
        check({tag, " ready cycle"}, rdy, exp_rdy);
        check({tag, " busy held"}, busy_bad, 0);
        if (rdy >= 0 && t >= 0) begin
            check({tag, " busy after"}, busy, 0);
            check({tag, " auto flag"}, auto_trig, forced);
            sweep(dec, t, bad);
            check({tag, " frame sweep"}, bad, 0);
        end
    endtask

    initial begin
        int rdy;
        logic [7:0] d0;
        logic [7:0] d1;

        vecs[0] = '{0, 1'b0, 8'h80, M_UP, 8'h78, 1031,
                    512, 8'h80, 511, 8'h7F, 0, 8'h80};
        vecs[1] = '{0, 1'b1, 8'h40, M_DN, 8'h48, 1031,
                    512, 8'h40, 511, 8'h41, 0, 8'h40};
        vecs[2] = '{0, 1'b1, 8'h40, M_UPDN, 0, 1037,
                    512, 8'h40, 511, 8'h42, 0, 8'h30};
        vecs[3] = '{2, 1'b1, 8'h00, M_CNT, 0, 4092,
                    512, 8'h00, 511, 8'hFC, 513, 8'h04};

        rst        = 1'b1;
        arm        = 1'b0;
        ad_data_in = 8'h00;
        trig_level = 8'h00;
        trig_edge  = 1'b0;
        fre_choose = 2'd0;
        rd_addr    = '0;
        repeat (3) @(posedge ad_clk);
        #1;
        check("reset busy", busy, 0);
        check("reset ready", frame_ready, 0);
        check("reset auto", auto_trig, 0);
        check("reset rd_data", rd_data, 0);
        rst = 1'b0;
        repeat (2) @(posedge ad_clk);
        #1;
        check("idle busy", busy, 0);

        for (int i = 0; i < 4; i++) begin
            full_capture(vecs[i].fre, vecs[i].fall, vecs[i].lvl,
                         vecs[i].mode, vecs[i].base, 6000,
                         $sformatf("vec%0d", i), rdy);
            check($sformatf("vec%0d table ready", i), rdy, vecs[i].rdy);
            read_at(vecs[i].a0, d0);
            check($sformatf("vec%0d rd%0d", i, vecs[i].a0), d0, vecs[i].e0);
            read_at(vecs[i].a1, d0);
            check($sformatf("vec%0d rd%0d", i, vecs[i].a1), d0, vecs[i].e1);
            read_at(vecs[i].a2, d0);
            check($sformatf("vec%0d rd%0d", i, vecs[i].a2), d0, vecs[i].e2);
        end
        read_at(100, d0);
        read_at(101, d1);
        check("decim step", 8'(d1 - d0), 4);

        for (int r = 0; r < 5; r++) begin
            int dec;
            bit fall;
            int lvl;
            dec  = $urandom_range(0, 1);
            fall = 1'($urandom_range(0, 1));
            lvl  = fall ? $urandom_range(0, 254) : $urandom_range(1, 255);
            full_capture(dec, fall, lvl, M_RAND, 0, (DEPTH + 3000) << dec,
                         $sformatf("rand%0d", r), rdy);
        end

        arm_cfg(0, 1'b0, 8'h80);
        busy_bad = 0;
        drive(621, M_UP, 8'h78, rdy);
        check("abort no early ready", rdy, -1);
        check("abort busy in post", busy, 1);
        full_capture(0, 1'b1, 8'h40, M_DN, 8'h48, 6000, "abort", rdy);
        check("abort new ready", rdy, 1031);

        arm_cfg(0, 1'b0, 8'h80);
        busy_bad = 0;
        drive(1031, M_UP, 8'h78, rdy);
        check("coincide pre ready", rdy, -1);
        full_capture(0, 1'b0, 8'h80, M_UP, 8'h30, 6000, "coincide", rdy);

        full_capture(0, 1'b0, 8'h80, M_CONST, 8'h10, 10000, "auto", rdy);
`ifdef OSC_AUTO_TRIG_EN
        check("auto ready", rdy, 1038);
        check("auto flag set", auto_trig, 1);
        read_at(512, d0);
        check("auto trig sample", d0, 8'h10);
`else
        check("no auto ready", rdy, -1);
        check("auto tied low", auto_trig, 0);
        check("still waiting", busy, 1);
`endif

        arm_cfg(0, 1'b0, 8'h80);
        busy_bad = 0;
        drive(515, M_CONST, 8'h10, rdy);
        check("rst pre busy", busy, 1);
        rst = 1'b1;
        @(posedge ad_clk);
        #1;
        check("rst busy", busy, 0);
        check("rst ready", frame_ready, 0);
        check("rst rd_data", rd_data, 0);
        check("rst auto", auto_trig, 0);
        arm = 1'b1;
        @(posedge ad_clk);
        #1;
        arm = 1'b0;
        check("arm in rst ignored", busy, 0);
        rst = 1'b0;
        repeat (3) @(posedge ad_clk);
        #1;
        check("idle after rst", busy, 0);
        check("no frame after rst", frame_ready, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
